// File: rtl/ntr_cmd_sequencer.sv
// NTR bus front end: synchronizes ntr_clk/ntr_data, frames 8-byte commands plus a
// counted data phase, and hands commands off over valid/ready. Option: NTR_CMD_MATCH_EN.
module ntr_cmd_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter logic [63:0] MATCH_CMD   = 64'h9F00_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ntr_clk,
  input  logic [7:0]  ntr_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [63:0] cmd_data,
  output logic        cmd_overrun,
  output logic        cmd_abort,
  output logic        xfer_done,
  output logic [15:0] data_count,
  output logic        led
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   clk_prev;
  logic                   ntr_edge;
  logic [7:0]             byte_in;

  logic [1:0]        state, state_n;
  logic [2:0]        idx, idx_n;
  logic [55:0]       shift, shift_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic [15:0]       live_cnt, live_cnt_n;
  logic              cmd_valid_n, cmd_overrun_n, cmd_abort_n, xfer_done_n, led_n;
  logic [63:0]       cmd_data_n;
  logic [15:0]       data_count_n;
  logic              complete, idle_hit;

  // Identical synchronizer chains keep clock and data aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      clk_prev <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync[i] <= 8'd0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      data_sync[0] <= ntr_data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign ntr_edge = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign byte_in  = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      shift       <= 56'd0;
      idle_cnt    <= '0;
      live_cnt    <= 16'd0;
      cmd_valid   <= 1'b0;
      cmd_data    <= 64'd0;
      cmd_overrun <= 1'b0;
      cmd_abort   <= 1'b0;
      xfer_done   <= 1'b0;
      data_count  <= 16'd0;
      led         <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      shift       <= shift_n;
      idle_cnt    <= idle_cnt_n;
      live_cnt    <= live_cnt_n;
      cmd_valid   <= cmd_valid_n;
      cmd_data    <= cmd_data_n;
      cmd_overrun <= cmd_overrun_n;
      cmd_abort   <= cmd_abort_n;
      xfer_done   <= xfer_done_n;
      data_count  <= data_count_n;
      led         <= led_n;
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    shift_n       = shift;
    live_cnt_n    = live_cnt;
    cmd_valid_n   = cmd_valid;
    cmd_data_n    = cmd_data;
    cmd_overrun_n = cmd_overrun;
    cmd_abort_n   = 1'b0;
    xfer_done_n   = 1'b0;
    data_count_n  = data_count;
    led_n         = led;
    complete      = 1'b0;

    if (ntr_edge) idle_cnt_n = '0;
    else if (idle_cnt != IDLE_W'(IDLE_CYCLES)) idle_cnt_n = idle_cnt + 1'b1;
    else idle_cnt_n = idle_cnt;
    // Timeout acts on the edge where the counter arrives at its limit
    idle_hit = !ntr_edge && (idle_cnt_n == IDLE_W'(IDLE_CYCLES));

    if (cmd_valid && cmd_ready) cmd_valid_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ntr_edge) begin
          shift_n = {48'd0, byte_in};
          idx_n   = 3'd1;
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ntr_edge) begin
          shift_n = {shift[47:0], byte_in};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            complete   = 1'b1;
            live_cnt_n = 16'd0;
            state_n    = ST_DATA;
          end
        end else if (idle_hit) begin
          cmd_abort_n = 1'b1;
          shift_n     = 56'd0;
          idx_n       = 3'd0;
          state_n     = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (ntr_edge) begin
          if (live_cnt != 16'hFFFF) live_cnt_n = live_cnt + 16'd1;
        end else if (idle_hit) begin
          data_count_n = live_cnt;
          xfer_done_n  = 1'b1;
          live_cnt_n   = 16'd0;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A same-cycle accept frees the holding register for the new command
    if (complete) begin
      if (!cmd_valid || cmd_ready) begin
        cmd_data_n  = {shift, byte_in};
        cmd_valid_n = 1'b1;
`ifdef NTR_CMD_MATCH_EN
        if ({shift, byte_in} == MATCH_CMD) led_n = 1'b1;
`else
        led_n = ~led;
`endif
      end else begin
        cmd_overrun_n = 1'b1;
      end
    end
  end

`ifndef NTR_CMD_MATCH_EN
  logic unused_match;
  assign unused_match = ^MATCH_CMD;
`endif

endmodule

// File: tb/tb_ntr_cmd_sequencer.sv
// Scoreboard bench for ntr_cmd_sequencer: expected commands are queued as bytes are
// driven and compared when the DUT hands a command off.
module tb_ntr_cmd_sequencer;

  localparam logic [63:0] MATCH = 64'h9F00_0000_0000_0000;

  logic        clk, rst, ntr_clk, cmd_ready;
  logic [7:0]  ntr_data;
  logic        cmd_valid, cmd_overrun, cmd_abort, xfer_done, led;
  logic [63:0] cmd_data;
  logic [15:0] data_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_abort  = 0;
  int n_vcyc   = 0;
  int n_vrise  = 0;
  logic valid_d = 1'b0;
  logic led_exp = 1'b0;
  logic [63:0] exp_q [$];

  ntr_cmd_sequencer #(.SYNC_STAGES(2), .IDLE_CYCLES(16), .MATCH_CMD(MATCH)) dut (
    .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .ntr_data(ntr_data),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_overrun(cmd_overrun), .cmd_abort(cmd_abort), .xfer_done(xfer_done),
    .data_count(data_count), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handoff monitor and pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (xfer_done) n_xfer++;
      if (cmd_abort) n_abort++;
      if (cmd_valid) n_vcyc++;
      if (cmd_valid && !valid_d) n_vrise++;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) check("unexpected_cmd", cmd_data, 64'hX);
        else check("cmd_data", cmd_data, exp_q.pop_front());
      end
    end
    valid_d = cmd_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit acc);
    ntr_data = b;
    ntr_clk  = 1'b0;
    repeat (3) tick();
    ntr_clk = 1'b1;
    if (acc) begin
      repeat (2) tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
    end else begin
      repeat (3) tick();
    end
    ntr_clk = 1'b0;
  endtask

  task automatic send_cmd(input logic [63:0] c, input bit acc_last);
    for (int i = 7; i >= 0; i--) send_byte(c[i*8 +: 8], acc_last && (i == 0));
  endtask

  task automatic expect_load(input logic [63:0] c);
    exp_q.push_back(c);
`ifdef NTR_CMD_MATCH_EN
    led_exp = led_exp | (c == MATCH);
`else
    led_exp = ~led_exp;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    led_exp = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, 64'(cmd_valid), 64'd0);
    check({pfx, "_data"}, cmd_data, 64'd0);
    check({pfx, "_overrun"}, 64'(cmd_overrun), 64'd0);
    check({pfx, "_abort"}, 64'(cmd_abort), 64'd0);
    check({pfx, "_xfer"}, 64'(xfer_done), 64'd0);
    check({pfx, "_count"}, 64'(data_count), 64'd0);
    check({pfx, "_led"}, 64'(led), 64'd0);
  endtask

  int x0, a0, v0, r0;

  initial begin
    rst = 1'b1; ntr_clk = 1'b0; ntr_data = 8'd0; cmd_ready = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Basic command with consumer always ready
    cmd_ready = 1'b1;
    x0 = n_xfer; v0 = n_vcyc;
    expect_load(64'hFF00_0000_0000_0001);
    send_cmd(64'hFF00_0000_0000_0001, 1'b0);
    idle(30);
    check("basic_valid_cycles", 64'(n_vcyc - v0), 64'd1);
    check("basic_xfer", 64'(n_xfer - x0), 64'd1);
    check("basic_count", 64'(data_count), 64'd0);
    check("basic_led", 64'(led), 64'(led_exp));

    // Command followed by five data bytes
    x0 = n_xfer;
    expect_load(MATCH);
    send_cmd(MATCH, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0);
    idle(30);
    check("data_count", 64'(data_count), 64'd5);
    check("data_xfer", 64'(n_xfer - x0), 64'd1);
    check("data_led", 64'(led), 64'(led_exp));

    // Partial command aborts, next command is clean
    a0 = n_abort; r0 = n_vrise; x0 = n_xfer;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i), 1'b0);
    idle(25);
    check("partial_abort", 64'(n_abort - a0), 64'd1);
    check("partial_valid", 64'(n_vrise - r0), 64'd0);
    check("partial_xfer", 64'(n_xfer - x0), 64'd0);
    expect_load(64'hA0A1_A2A3_A4A5_A6A7);
    send_cmd(64'hA0A1_A2A3_A4A5_A6A7, 1'b0);
    idle(30);
    check("after_abort_led", 64'(led), 64'(led_exp));
    check("after_abort_abort", 64'(n_abort - a0), 64'd1);

    // Overrun: second command dropped while first is held
    cmd_ready = 1'b0;
    tick();
    expect_load(64'h1122_3344_5566_7788);
    send_cmd(64'h1122_3344_5566_7788, 1'b0);
    idle(30);
    send_cmd(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    idle(30);
    check("ovr_valid", 64'(cmd_valid), 64'd1);
    check("ovr_data", cmd_data, 64'h1122_3344_5566_7788);
    check("ovr_flag", 64'(cmd_overrun), 64'd1);
    check("ovr_led", 64'(led), 64'(led_exp));
    cmd_ready = 1'b1;
    repeat (2) tick();
    check("ovr_valid_clr", 64'(cmd_valid), 64'd0);
    check("ovr_sticky", 64'(cmd_overrun), 64'd1);

    // Accept and completion on the same edge
    do_reset();
    check("rst_overrun", 64'(cmd_overrun), 64'd0);
    cmd_ready = 1'b0;
    expect_load(64'h0102_0304_0506_0708);
    send_cmd(64'h0102_0304_0506_0708, 1'b0);
    idle(30);
    expect_load(64'hC0C1_C2C3_C4C5_C6C7);
    send_cmd(64'hC0C1_C2C3_C4C5_C6C7, 1'b1);
    check("simul_valid", 64'(cmd_valid), 64'd1);
    check("simul_data", cmd_data, 64'hC0C1_C2C3_C4C5_C6C7);
    check("simul_overrun", 64'(cmd_overrun), 64'd0);
    idle(30);
    check("simul_overrun_late", 64'(cmd_overrun), 64'd0);
    cmd_ready = 1'b1;
    repeat (2) tick();
    check("simul_valid_clr", 64'(cmd_valid), 64'd0);
    check("simul_led", 64'(led), 64'(led_exp));

    // Reset in the middle of a command
    for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b0);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    led_exp = 1'b0;
    tick();
    expect_load(64'h1357_9BDF_2468_ACE0);
    send_cmd(64'h1357_9BDF_2468_ACE0, 1'b0);
    idle(30);
    check("midrst_led", 64'(led), 64'(led_exp));
    check("midrst_overrun", 64'(cmd_overrun), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntr_cmd_sequencer.md
# ntr_cmd_sequencer

Front-end controller for the NTR cartridge bus sniffer. Synchronizes the external `ntr_clk`/`ntr_data` pair into the `clk` domain, frames each transaction into an 8-byte command phase plus a counted data phase, and delivers completed commands over a valid/ready handshake. It sits between the NTR pins and the command decoder/LED logic in `top`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `ntr_clk` and `ntr_data`. Legal values are 2 and above.
- `IDLE_CYCLES`, 16: number of `clk` cycles without an `ntr_clk` rise that ends a transaction. Legal values are 2 and above.
- `MATCH_CMD`, 64'h9F00_0000_0000_0000: command compared against when `NTR_CMD_MATCH_EN` is defined.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ntr_clk` in 1: bus clock, asynchronous to `clk`. A byte is latched on each rising edge.
- `ntr_data` in 8: bus data.
- `cmd_ready` in 1: consumer accepts the command.
- `cmd_valid` out 1: a command is held in `cmd_data`.
- `cmd_data` out 64: command. The first byte is in [63:56] and the eighth byte is in [7:0].
- `cmd_overrun` out 1: sticky flag. A command completed while `cmd_valid` was high.
- `cmd_abort` out 1: 1-cycle pulse. A partial command ended by idle timeout.
- `xfer_done` out 1: 1-cycle pulse. A transaction with a complete command ended by idle timeout.
- `data_count` out 16: number of data-phase bytes in the last finished transaction. Saturates at 16'hFFFF.
- `led` out 1: status indicator (see Configuration).

## Operation
- Synchronization:
  - `ntr_clk` and `ntr_data` pass through identical `SYNC_STAGES`-deep flop chains.
  - `edge` is high for one cycle when the last stage of the clock chain is 1 and the previous-cycle copy is 0.
  - `byte_in` is the last stage of the data chain.
- State machine: IDLE → CMD → DATA → IDLE.
  - IDLE: on `edge`, capture `byte_in` as byte 0, set byte index to 1, go to CMD.
  - CMD: on `edge`, shift `byte_in` into the command shift register and increment the index. On capture of byte index 7, go to DATA.
  - DATA: on `edge`, increment the live data counter. The counter saturates at 16'hFFFF.
- Idle counter:
  - Reset to 0 on every `edge`; otherwise increments, saturating at `IDLE_CYCLES`.
  - In CMD, reaching `IDLE_CYCLES` means: pulse `cmd_abort`, discard the partial bytes, go to IDLE.
  - In DATA, reaching `IDLE_CYCLES` means: copy the live counter to `data_count`, pulse `xfer_done`, clear the live counter, go to IDLE.
  - In IDLE the counter has no effect.
- Command handoff:
  - When byte 7 is captured and `cmd_valid` is 0: load `cmd_data`, set `cmd_valid`.
  - When byte 7 is captured and `cmd_valid` is 1: drop the new command, set `cmd_overrun`. `cmd_data` is unchanged.
  - `cmd_valid` clears on the cycle where `cmd_valid && cmd_ready`.
  - If acceptance and a new completion fall on the same cycle, the new command loads, `cmd_valid` stays 1, and there is no overrun.
  - `cmd_overrun` clears only on `rst`.
- Reset values:
  - `cmd_valid`, `cmd_overrun`, `cmd_abort`, `xfer_done` and `led` are 0.
  - `cmd_data` and `data_count` are 0.
  - State is IDLE, and all sync flops are 0.
- Reset mid-transaction discards everything. After `rst` falls, the first `edge` is byte 0.

## Timing
- A rise of `ntr_clk` first sampled at clk edge N:
  - `edge` is high in the cycle after edge N+SYNC_STAGES−1.
  - The byte is registered at edge N+SYNC_STAGES.
- `cmd_valid` rises at the same clk edge that registers byte 7.
- `cmd_abort` and `xfer_done` are high for exactly the cycle after the idle counter reaches `IDLE_CYCLES`.
- `ntr_data` must be stable for at least SYNC_STAGES+1 clk cycles around each `ntr_clk` rise.
- `ntr_clk` high and low times must each be at least 2 clk cycles.
- Throughput: one byte per `ntr_clk` period. There are no stalls; the handshake never back-pressures the bus.

## Configuration
- `NTR_CMD_MATCH_EN` defined:
  - `led` sets to 1 when a loaded command equals `MATCH_CMD`.
  - `led` stays set until `rst`.
  - Dropped (overrun) commands are not compared.
- `NTR_CMD_MATCH_EN` undefined:
  - `led` toggles on every command loaded into `cmd_data`.
  - `MATCH_CMD` is unused and no comparator is built.

## Test plan
- Basic command: `clk` period 2, `ntr_clk` period 10, bytes FF,00,00,00,00,00,00,01, `cmd_ready` held 1.
  - `cmd_valid` pulses for 1 cycle with `cmd_data` = 64'hFF00_0000_0000_0001.
  - After 16 idle cycles, `xfer_done` pulses with `data_count` = 0.
- Data phase: command 9F00000000000000 followed by 5 data bytes, then idle.
  - `data_count` = 5, with one `xfer_done` pulse.
  - With the macro defined, `led` = 1.
- Partial command: 3 bytes, then idle for 20 cycles.
  - `cmd_abort` pulses once; `cmd_valid` stays 0.
  - The next 8 bytes A0..A7 yield 64'hA0A1_A2A3_A4A5_A6A7.
- Overrun: `cmd_ready` held 0, two back-to-back commands (each followed by an idle gap).
  - `cmd_data` holds the first command and `cmd_overrun` = 1.
  - Raising `cmd_ready` clears `cmd_valid`; `cmd_overrun` stays 1.
- Simultaneous accept and complete: assert `cmd_ready` on the exact cycle the second command's byte 7 registers.
  - `cmd_valid` stays 1, `cmd_data` becomes the second command, `cmd_overrun` stays 0.
- Reset mid-command: pulse `rst` after byte 4.
  - All outputs return to 0.
  - The next 8 bytes form a clean command.
  - Macro undefined: `led` toggles to 1.
